hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Execute-stage consumer of the 5-bit ALU control code for the HI/LO instruction group: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI/LO registers and runs an iterative divider, plus a multiplier that is either iterative or single-cycle.
- Stalls the pipeline while an operation is in flight.
- MFHI/MFLO read hi_o/lo_o directly.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start_i  in  1  valid instruction present in the E stage.
- alucontrol_i  in  5  E-stage ALU control code; compared against the shared *_CONTROL constants.
- srca_i  in  32  rs operand, forwarded.
- srcb_i  in  32  rt operand, forwarded.
- flush_i  in  1  exception/flush of the E stage.
- hold_i  in  1  E-stage stall from other sources; excludes stall_o.
- stall_o  out  1  request to freeze F/D/E.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.

Behaviour:
- Reset: HI=0, LO=0, state=IDLE, counter=0, stall_o=0. Reset mid-operation aborts the operation.
- States: IDLE, RUN, DONE.
- accept = start_i & state==IDLE & !flush_i & op in {MULT, MULTU, DIV, DIVU, MTHI, MTLO}.
- MTHI/MTLO: at the accept edge, HI (resp. LO) <= srca_i. No stall. Stay in IDLE.
- DIV/DIVU accept:
  - Latch operand magnitudes (signed ops only) and result signs: quotient sign = sa^sb, remainder sign = sa.
  - counter <= 0, state <= RUN.
- RUN:
  - One restoring-division step per cycle.
  - At the edge where counter==31 (and !flush_i): apply sign fixup, write LO=quotient and HI=remainder, state <= DONE.
- Divide timing: stall_o is high in the accept cycle plus 32 RUN cycles, i.e. 33 cycles. HI/LO are valid in the DONE cycle.
- DONE:
  - stall_o=0; start_i is ignored.
  - Stay in DONE while hold_i=1, so the held instruction is not restarted.
  - Go to IDLE when hold_i=0.
- stall_o = (start_i & state==IDLE & op is MULT/MULTU/DIV/DIVU & !flush_i & not a zero-stall case) | state==RUN.
- Divide by zero (srcb_i==0 at accept): HI/LO unchanged, no stall, stay in IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- Multiply (iterative, default):
  - Shift-add over 32 RUN cycles; same stall/DONE timing as divide.
  - Signed result: 64-bit two's-complement product. HI = product[63:32], LO = product[31:0].
- flush_i:
  - In RUN: abort; state <= IDLE at the next edge; HI/LO untouched; stall_o drops combinationally.
  - In IDLE: suppresses accept.
  - At the commit edge: no write.
- hold_i=1 in the accept cycle does not block accept. Re-presentation of the same instruction is prevented by DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a combinational 32x32 multiply.
  - HI/LO are written at the accept edge; no stall; state stays IDLE.
  - Back-to-back multiplies have zero stall.
- Undefined: iterative 32-cycle shift-add multiply as described above.

Decomposition:
- Shared header (existing defines header): *_CONTROL codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Local to this module: state encoding IDLE/RUN/DONE and the iteration count of 32.
- Sub-module div_core:
  - Unsigned restoring iteration datapath: remainder/quotient shift registers, subtractor, counter.
  - Shared by divide and the iterative multiply.
- hilo_muldiv keeps the FSM, sign handling, and HI/LO.

Test Plan:
- DIVU 100/7 → stall_o high exactly 33 cycles; then LO=14, HI=2; DONE lasts 1 cycle with hold_i=0.
- DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF * 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands → HI=1, LO=0xFFFFFFFE.
  - Stall is 33 cycles without MULDIV_FAST_MUL_EN and 0 cycles with it.
- MTHI 0x11, MTLO 0x22, then DIV x/0 → no stall; hi_o=0x11, lo_o=0x22 unchanged.
- DIVU started, flush_i at RUN cycle 10 → stall_o low the same cycle; HI/LO unchanged; a new DIVU in the next cycle completes normally.
- Mid-RUN resetn=0 → HI=LO=0 and stall_o=0 immediately. After release, MTHI 0xDEADBEEF → hi_o=0xDEADBEEF the next cycle.
  - Also: DONE held 3 cycles via hold_i=1 → no restart and HI/LO stable.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared ALU control codes and local definitions for the HI/LO multiply/divide unit.
// Optional feature macro used by this slice: MULDIV_FAST_MUL_EN (single-cycle multiply).
package hilo_muldiv_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11101;

  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Magnitude of a 32-bit operand when it is interpreted as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned iteration datapath shared by restoring division and shift-add multiply.
// o_hi_next/o_lo_next expose the result of the step taken at the next edge.
module div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_mul,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi_next,
  output logic [WIDTH-1:0] o_lo_next
);

  localparam int unsigned CW = $clog2(ITERATIONS);

  logic             r_mul;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_sum;

  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  // Multiply: {r_hi, r_lo} is the product accumulator with the multiplier in r_lo.
  always_comb begin
    w_shift   = {r_hi, r_lo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_b};
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    o_hi_next = r_hi;
    o_lo_next = r_lo;
    if (r_mul) begin
      o_hi_next = w_sum[WIDTH:1];
      o_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      o_hi_next = w_diff[WIDTH-1:0];
      o_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      o_hi_next = w_shift[WIDTH-1:0];
      o_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign o_last = (r_count == CW'(ITERATIONS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mul   <= 1'b0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_mul   <= i_mul;
      r_b     <= i_b;
      r_hi    <= '0;
      r_lo    <= i_a;
      r_count <= '0;
    end else if (i_step) begin
      r_hi    <= o_hi_next;
      r_lo    <= o_lo_next;
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO with pipeline stall.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [4:0]       alucontrol_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t r_state, w_next;

  logic r_is_mul, r_neg_lo, r_neg_hi;
  logic w_op_mul, w_op_div, w_op_mthi, w_op_mtlo, w_signed;
  logic w_iter, w_accept, w_launch, w_commit, w_last, w_sa, w_sb;
  logic [WIDTH-1:0]   w_core_hi, w_core_lo;
  logic [2*WIDTH-1:0] w_prod, w_result;

  assign w_op_mul  = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == MULTU_CONTROL);
  assign w_op_div  = (alucontrol_i == DIV_CONTROL)  || (alucontrol_i == DIVU_CONTROL);
  assign w_op_mthi = (alucontrol_i == MTHI_CONTROL);
  assign w_op_mtlo = (alucontrol_i == MTLO_CONTROL);
  assign w_signed  = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == DIV_CONTROL);
  assign w_sa      = w_signed & srca_i[WIDTH-1];
  assign w_sb      = w_signed & srcb_i[WIDTH-1];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_iter      = w_op_div;
  assign w_fast_prod = {{WIDTH{w_sa}}, srca_i} * {{WIDTH{w_sb}}, srcb_i};
`else
  assign w_iter      = w_op_div | w_op_mul;
`endif

  assign w_accept = start_i && (r_state == S_IDLE) && !flush_i
                    && (w_op_mul || w_op_div || w_op_mthi || w_op_mtlo);
  assign w_launch = w_accept && w_iter && !(w_op_div && (srcb_i == '0));
  assign w_commit = (r_state == S_RUN) && !flush_i && w_last;

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_launch),
    .i_step    (r_state == S_RUN),
    .i_mul     (w_op_mul),
    .i_a       (abs32(srca_i, w_signed)),
    .i_b       (abs32(srcb_i, w_signed)),
    .o_last    (w_last),
    .o_hi_next (w_core_hi),
    .o_lo_next (w_core_lo)
  );

  // Sign fixup on the final step result: whole 64-bit negate for multiply,
  // separate quotient/remainder negates for divide.
  always_comb begin
    w_prod = {w_core_hi, w_core_lo};
    if (r_is_mul)
      w_result = r_neg_lo ? ('0 - w_prod) : w_prod;
    else
      w_result = {r_neg_hi ? ('0 - w_core_hi) : w_core_hi,
                  r_neg_lo ? ('0 - w_core_lo) : w_core_lo};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_RUN;
      S_RUN:   if (flush_i) w_next = S_IDLE;
               else if (w_last) w_next = S_DONE;
      S_DONE:  if (!hold_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = w_launch || ((r_state == S_RUN) && !flush_i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_mul <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      if (w_launch) begin
        r_is_mul <= w_op_mul;
        r_neg_lo <= w_sa ^ w_sb;
        r_neg_hi <= w_sa;
      end
      if (w_accept && w_op_mthi) hi_o <= srca_i;
      if (w_accept && w_op_mtlo) lo_o <= srca_i;
`ifdef MULDIV_FAST_MUL_EN
      if (w_accept && w_op_mul) {hi_o, lo_o} <= w_fast_prod;
`endif
      if (w_commit) {hi_o, lo_o} <= w_result;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed table, flush/reset/hold sequences,
// and randomized operations against an arithmetic reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, flush_i, hold_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] srca_i, srcb_i;
  logic        stall_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
    int          stall;
  } vec_t;

  vec_t tbl[8];

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .alucontrol_i (alucontrol_i),
    .srca_i       (srca_i),
    .srcb_i       (srcb_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo} and the expected stall length.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int stall);
    logic [63:0] p;
    longint na, nb, q, r;
    stall = 0;
    case (op)
      MTHI_CONTROL: hi = a;
      MTLO_CONTROL: lo = a;
      MULT_CONTROL, MULTU_CONTROL: begin
        if (op == MULT_CONTROL) p = longint'($signed(a)) * longint'($signed(b));
        else                    p = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
        stall = MUL_STALL;
      end
      DIV_CONTROL, DIVU_CONTROL: begin
        if (b != 0) begin
          if (op == DIV_CONTROL) begin
            na = longint'($signed(a)); nb = longint'($signed(b));
          end else begin
            na = longint'({32'd0, a}); nb = longint'({32'd0, b});
          end
          q = na / nb;
          r = na % nb;
          lo = q[31:0];
          hi = r[31:0];
          stall = 33;
        end
      end
      default: ;
    endcase
  endtask

  // Present one instruction, hold it while stalled, and check stall length and HI/LO.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int estall, input int hold_extra);
    int  n = 0;
    bit  done = 0;
    @(posedge clk); #1;
    start_i = 1'b1; alucontrol_i = op; srca_i = a; srcb_i = b;
    flush_i = 1'b0; hold_i = (hold_extra != 0);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall_o) begin
        n++;
        @(posedge clk); #1;
      end else done = 1;
    end
    if (!done) chk({name, " timeout"}, 64'd0, 64'd1);
    chk({name, " stall"}, 64'(n), 64'(estall));
    if (n > 0) begin
      chk({name, " hi@done"}, {32'd0, hi_o}, {32'd0, ehi});
      chk({name, " lo@done"}, {32'd0, lo_o}, {32'd0, elo});
    end
    for (int k = 0; k < hold_extra; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, " held stall"}, {63'd0, stall_o}, 64'd0);
      chk({name, " held hi/lo"}, {hi_o, lo_o}, {ehi, elo});
    end
    @(posedge clk); #1;
    start_i = 1'b0; hold_i = 1'b0;
    @(negedge clk);
    chk({name, " hi"}, {32'd0, hi_o}, {32'd0, ehi});
    chk({name, " lo"}, {32'd0, lo_o}, {32'd0, elo});
    chk({name, " idle stall"}, {63'd0, stall_o}, 64'd0);
  endtask

  initial begin
    logic [4:0] ops[6];
    logic [4:0] op;
    logic [31:0] a, b, ehi, elo;
    int st;

    ops[0] = MULT_CONTROL; ops[1] = MULTU_CONTROL; ops[2] = DIV_CONTROL;
    ops[3] = DIVU_CONTROL; ops[4] = MTHI_CONTROL;  ops[5] = MTLO_CONTROL;

    tbl[0] = '{DIVU_CONTROL,  32'd100,        32'd7,          32'd2,          32'd14,         33};
    tbl[1] = '{DIV_CONTROL,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   33};
    tbl[2] = '{DIV_CONTROL,   32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33};
    tbl[3] = '{MULT_CONTROL,  32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFE,   MUL_STALL};
    tbl[4] = '{MULTU_CONTROL, 32'hFFFFFFFF,   32'd2,          32'd1,          32'hFFFFFFFE,   MUL_STALL};
    tbl[5] = '{MTHI_CONTROL,  32'h11,         32'd0,          32'h11,         32'hFFFFFFFE,   0};
    tbl[6] = '{MTLO_CONTROL,  32'h22,         32'd0,          32'h11,         32'h22,         0};
    tbl[7] = '{DIV_CONTROL,   32'd1234,       32'd0,          32'h11,         32'h22,         0};

    resetn = 1'b0; start_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    alucontrol_i = '0; srca_i = '0; srcb_i = '0;
    #12;
    chk("reset hi", {32'd0, hi_o}, 64'd0);
    chk("reset lo", {32'd0, lo_o}, 64'd0);
    chk("reset stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].hi, tbl[i].lo, tbl[i].stall, 0);
    m_hi = 32'h11; m_lo = 32'h22;

    // DONE held by hold_i: the still-presented DIVU must not restart.
    do_op("hold", DIVU_CONTROL, 32'd1000, 32'd9, 32'd1, 32'd111, 33, 3);
    m_hi = 32'd1; m_lo = 32'd111;

    // Flush in the 10th RUN cycle aborts without touching HI/LO.
    @(posedge clk); #1;
    start_i = 1'b1; alucontrol_i = DIVU_CONTROL; srca_i = 32'd77; srcb_i = 32'd5;
    @(negedge clk);
    chk("flush accept stall", {63'd0, stall_o}, 64'd1);
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush stall drop", {63'd0, stall_o}, 64'd0);
    chk("flush hi/lo", {hi_o, lo_o}, {m_hi, m_lo});
    do_op("after flush", DIVU_CONTROL, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 0);
    m_hi = 32'd1; m_lo = 32'd333;

    // Asynchronous reset mid-RUN.
    @(posedge clk); #1;
    start_i = 1'b1; alucontrol_i = DIVU_CONTROL; srca_i = 32'd50; srcb_i = 32'd5;
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0; start_i = 1'b0;
    #1;
    chk("midrun reset hi", {32'd0, hi_o}, 64'd0);
    chk("midrun reset lo", {32'd0, lo_o}, 64'd0);
    chk("midrun reset stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    do_op("mthi after reset", MTHI_CONTROL, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0, 0, 0);
    m_hi = 32'hDEADBEEF; m_lo = 32'd0;

    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      ehi = m_hi; elo = m_lo;
      model(op, a, b, ehi, elo, st);
      do_op($sformatf("rand%0d op%0h", i, op), op, a, b, ehi, elo, st, 0);
      m_hi = ehi; m_lo = elo;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
